mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory-access stage of the LC-3b pipeline. Sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Sequences data-memory transactions: LDR/STR, LDB/STB, and the two-access LDI/STI.
- Freezes the upstream pipeline while a transaction is outstanding, then presents the loaded word to writeback.

Parameters:
- WORD_W, 16, data/address width (matches lc3b_word)
- IND_EN, 1, 1 = LDI/STI indirect sequencing enabled; 0 = is_indirect_in ignored

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- valid_in  in  1  EX/MEM register holds a live instruction
- mem_read_in  in  1  instruction loads (from EX/MEM)
- mem_write_in  in  1  instruction stores (from EX/MEM)
- is_byte_in  in  1  LDB/STB
- is_indirect_in  in  1  LDI/STI
- addr_in  in  16  effective address (addr_adder_out from EX/MEM)
- store_data_in  in  16  store source (dest_data from EX/MEM)
- dmem_rdata  in  16  data-memory read data
- dmem_resp  in  1  data-memory completes current access this cycle
- dmem_address  out  16  data-memory address
- dmem_read  out  1  read strobe
- dmem_write  out  1  write strobe
- dmem_byte_enable  out  2  write lane enables, [1] = high byte
- dmem_wdata  out  16  write data
- load_data_out  out  16  loaded value for MEM/WB (registered)
- stall_out  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- done_out  out  1  one-cycle pulse: memory op retired, MEM/WB may capture

Behaviour:
- Reset (asynchronous, any state): state = IDLE; load_data_out = 0; pointer register = 0; dmem_read = dmem_write = 0; dmem_byte_enable = 00; dmem_address = 0; dmem_wdata = 0; stall_out = 0; done_out = 0.
- req = valid_in & (mem_read_in | mem_write_in). If both read and write are set, read wins and no write is issued.
- FSM states:
  - IDLE: strobes low. If req and is_indirect_in & IND_EN -> IND; else if req -> ACC; else stay in IDLE.
  - IND: dmem_read = 1, dmem_address = {addr_in[15:1],0}, byte_enable = 00. On dmem_resp, capture dmem_rdata into the pointer register and go to ACC. Otherwise stay.
  - ACC: effective address ea = pointer register if indirect, else addr_in. Word access: dmem_address = {ea[15:1],0}. Byte access: dmem_address = ea.
    - Read: dmem_read = 1.
    - Write, word: dmem_write = 1, byte_enable = 11, wdata = store_data_in.
    - Write, byte: wdata = {store_data_in[7:0], store_data_in[7:0]}, byte_enable = ea[0] ? 10 : 01.
    - On dmem_resp with a read: load_data_out <= word, or for byte SEXT(ea[0] ? rdata[15:8] : rdata[7:0]). Then go to HOLD.
    - On dmem_resp with a write: load_data_out is unchanged. Then go to HOLD.
  - HOLD: strobes low; done_out = 1; stall_out = 0; next state IDLE. Exactly one cycle, so the pipeline advances once per retired op.
- stall_out = (IDLE & req) | IND | ACC. This is combinational from state and inputs.
- Strobes and address hold stable for every cycle of IND and ACC until dmem_resp. The inputs are stable meanwhile because EX/MEM is frozen.
- Latency from req seen in IDLE to done_out:
  - direct op: 3 cycles minimum (IDLE, ACC, HOLD)
  - indirect op: 4 cycles minimum
  - each wait cycle on dmem_resp adds one cycle.
- A non-memory instruction (req = 0) never stalls. load_data_out keeps its last value.
- dmem_resp outside IND/ACC is ignored.
- Reset asserted mid-transaction: the access is abandoned and strobes drop asynchronously. No retry occurs after reset.
- Back-to-back memory ops: the next op is accepted in the IDLE cycle that follows HOLD.

Decomposition:
- lc3b_types package: lc3b_word, lc3b_reg, lc3b_nzp; add lc3b_mem_state enum {IDLE, IND, ACC, HOLD}.
- One sub-module, mem_byte_align: combinational byte-lane select, sign-extension, write-data replication and byte_enable generation.

Test Plan:
- LDR: addr_in = 0x3005, mem_read, rdata = 0xBEEF, resp on 2nd ACC cycle -> dmem_address = 0x3004; stall_out high 3 cycles; load_data_out = 0xBEEF; done_out pulses once.
- LDB: addr_in = 0x3005, rdata = 0x80FF -> load_data_out = 0xFF80 (high byte, sign-extended); addr_in = 0x3004 -> 0xFFFF.
- STB: addr_in = 0x2001, store_data_in = 0x1234 -> dmem_wdata = 0x3434, byte_enable = 10, dmem_write held until resp; load_data_out unchanged.
- LDI: addr_in = 0x4000, first rdata = 0x5002, second rdata = 0x0A0A -> second access address 0x5002; load_data_out = 0x0A0A; stall_out spans IDLE+IND+ACC.
- STI with reset asserted during ACC -> strobes drop immediately, state IDLE, load_data_out = 0, stall_out = 0.
- Non-memory instruction back-to-back after STR -> no stall for the ALU op; done_out only for the STR.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// lc3b_types: shared LC-3b word/register types and the memory-stage state encoding
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [2:0]  lc3b_nzp;
  typedef enum logic [1:0] {IDLE, IND, ACC, HOLD} lc3b_mem_state;
  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;
endpackage

// File: rtl/mem_stage_ctrl_byte_align.sv
// mem_byte_align: byte-lane select with sign extension, store-data replication and lane enables
module mem_byte_align
  import lc3b_types::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              ea_lsb_i,
  input  logic              is_byte_i,
  input  logic [WORD_W-1:0] store_data_i,
  input  logic [WORD_W-1:0] rdata_i,
  output logic [WORD_W-1:0] load_o,
  output logic [WORD_W-1:0] wdata_o,
  output logic [1:0]        be_o
);
  logic [7:0] lane;
  assign lane    = ea_lsb_i ? rdata_i[15:8] : rdata_i[7:0];
  assign load_o  = is_byte_i ? {{(WORD_W-8){lane[7]}}, lane} : rdata_i;
  assign wdata_o = is_byte_i ? {store_data_i[7:0], store_data_i[7:0]} : store_data_i;
  assign be_o    = is_byte_i ? (ea_lsb_i ? BE_HI : BE_LO) : BE_WORD;
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: LC-3b memory stage sequencing direct and indirect data-memory accesses
module mem_stage_ctrl
  import lc3b_types::*;
#(
  parameter int WORD_W = 16,
  parameter bit IND_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              is_byte_in,
  input  logic              is_indirect_in,
  input  logic [WORD_W-1:0] addr_in,
  input  logic [WORD_W-1:0] store_data_in,
  input  logic [WORD_W-1:0] dmem_rdata,
  input  logic              dmem_resp,
  output logic [WORD_W-1:0] dmem_address,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [1:0]        dmem_byte_enable,
  output logic [WORD_W-1:0] dmem_wdata,
  output logic [WORD_W-1:0] load_data_out,
  output logic              stall_out,
  output logic              done_out
);
  lc3b_mem_state     state_q, state_d;
  logic [WORD_W-1:0] ptr_q, ptr_d, load_q, load_d, ea, al_load, al_wdata;
  logic [1:0]        al_be;
  logic              req, ind, wr;
  assign req = valid_in & (mem_read_in | mem_write_in);
  assign ind = IND_EN & is_indirect_in;
  assign wr  = mem_write_in & ~mem_read_in;
  assign ea  = ind ? ptr_q : addr_in;
  assign load_data_out = load_q;
  mem_byte_align #(.WORD_W(WORD_W)) u_align (
    .ea_lsb_i     (ea[0]),
    .is_byte_i    (is_byte_in),
    .store_data_i (store_data_in),
    .rdata_i      (dmem_rdata),
    .load_o       (al_load),
    .wdata_o      (al_wdata),
    .be_o         (al_be)
  );
  // state, fetched pointer and loaded value registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      load_q  <= load_d;
    end
  end
  // next state and memory strobes; stall is forced low while reset is held
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    load_d           = load_q;
    dmem_address     = '0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_byte_enable = BE_NONE;
    dmem_wdata       = '0;
    stall_out        = 1'b0;
    done_out         = 1'b0;
    case (state_q)
      IDLE: begin
        stall_out = !reset && req;
        state_d   = req ? (ind ? IND : ACC) : IDLE;
      end
      IND: begin
        stall_out    = !reset;
        dmem_read    = 1'b1;
        dmem_address = {addr_in[WORD_W-1:1], 1'b0};
        ptr_d        = dmem_resp ? dmem_rdata : ptr_q;
        state_d      = dmem_resp ? ACC : IND;
      end
      ACC: begin
        stall_out        = !reset;
        dmem_address     = is_byte_in ? ea : {ea[WORD_W-1:1], 1'b0};
        dmem_read        = mem_read_in;
        dmem_write       = wr;
        dmem_byte_enable = wr ? al_be : BE_NONE;
        dmem_wdata       = wr ? al_wdata : '0;
        load_d           = (dmem_resp && mem_read_in) ? al_load : load_q;
        state_d          = dmem_resp ? HOLD : ACC;
      end
      default: begin
        done_out = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed vector table plus reset, idle and back-to-back sequences
module tb_mem_stage_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        valid_in = 0, mem_read_in = 0, mem_write_in = 0, is_byte_in = 0, is_indirect_in = 0;
  logic [15:0] addr_in = 0, store_data_in = 0, dmem_rdata = 0;
  logic        dmem_resp = 0;
  logic [15:0] dmem_address, dmem_wdata, load_data_out;
  logic        dmem_read, dmem_write, stall_out, done_out;
  logic [1:0]  dmem_byte_enable;
  int checks = 0, errors = 0;

  typedef struct {
    logic rd, wr, byt, ind;
    logic [15:0] addr, sd, ptr, rdata;
    int waits;
    logic [15:0] e_iaddr, e_addr;
    logic e_rd, e_wr;
    logic [15:0] e_wdata;
    logic [1:0] e_be;
    logic [15:0] e_load;
    int e_stall;
  } vec_t;
  vec_t tv[10];

  mem_stage_ctrl #(.WORD_W(16), .IND_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .is_byte_in(is_byte_in), .is_indirect_in(is_indirect_in),
    .addr_in(addr_in), .store_data_in(store_data_in), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .dmem_address(dmem_address), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable), .dmem_wdata(dmem_wdata),
    .load_data_out(load_data_out), .stall_out(stall_out), .done_out(done_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic run_op(input int k, input vec_t v);
    int stall_n = 0, done_n = 0, acc = 0, wait_n = 0, cyc = 0;
    logic [15:0] a_ind = 0, a_fin = 0, wd = 0;
    logic [1:0] be = 0;
    logic r = 0, w = 0;
    bit fin = 0;
    valid_in = 1; mem_read_in = v.rd; mem_write_in = v.wr; is_byte_in = v.byt;
    is_indirect_in = v.ind; addr_in = v.addr; store_data_in = v.sd; dmem_resp = 0;
    while (!fin && cyc < 40) begin
      @(negedge clk);
      cyc++;
      dmem_resp = 0;
      stall_n += int'(stall_out);
      done_n  += int'(done_out);
      if (done_out) fin = 1;
      else if (dmem_read || dmem_write) begin
        if (wait_n < v.waits) wait_n++;
        else begin
          dmem_resp = 1;
          wait_n = 0;
          if (v.ind && acc == 0) begin
            a_ind = dmem_address;
            dmem_rdata = v.ptr;
          end else begin
            a_fin = dmem_address; r = dmem_read; w = dmem_write;
            wd = dmem_wdata; be = dmem_byte_enable;
            dmem_rdata = v.rdata;
          end
          acc++;
        end
      end
    end
    if (!fin) begin
      errors++; checks++;
      $display("FAIL v%0d timeout waiting for done_out", k);
    end
    @(posedge clk); #1;
    valid_in = 0;
    chk($sformatf("v%0d addr", k), a_fin, v.e_addr);
    chk($sformatf("v%0d read", k), 16'(r), 16'(v.e_rd));
    chk($sformatf("v%0d write", k), 16'(w), 16'(v.e_wr));
    if (v.e_wr) begin
      chk($sformatf("v%0d wdata", k), wd, v.e_wdata);
      chk($sformatf("v%0d byte_en", k), 16'(be), 16'(v.e_be));
    end
    if (v.ind) chk($sformatf("v%0d ind_addr", k), a_ind, v.e_iaddr);
    chk($sformatf("v%0d load", k), load_data_out, v.e_load);
    chk($sformatf("v%0d stall_cycles", k), 16'(stall_n), 16'(v.e_stall));
    chk($sformatf("v%0d done_pulses", k), 16'(done_n), 16'd1);
  endtask

  initial begin
    //        rd wr by in addr     sd       ptr      rdata   w  iaddr    addr   erd ewr wdata   be     load   stall
    tv[0] = '{1, 0, 0, 0, 16'h3005, 16'h0000, 16'h0000, 16'hBEEF, 1, 16'h0000, 16'h3004, 1, 0, 16'h0000, 2'b00, 16'hBEEF, 3};
    tv[1] = '{1, 0, 1, 0, 16'h3005, 16'h0000, 16'h0000, 16'h80FF, 0, 16'h0000, 16'h3005, 1, 0, 16'h0000, 2'b00, 16'hFF80, 2};
    tv[2] = '{1, 0, 1, 0, 16'h3004, 16'h0000, 16'h0000, 16'h80FF, 0, 16'h0000, 16'h3004, 1, 0, 16'h0000, 2'b00, 16'hFFFF, 2};
    tv[3] = '{0, 1, 1, 0, 16'h2001, 16'h1234, 16'h0000, 16'h0000, 2, 16'h0000, 16'h2001, 0, 1, 16'h3434, 2'b10, 16'hFFFF, 4};
    tv[4] = '{1, 0, 0, 1, 16'h4000, 16'h0000, 16'h5002, 16'h0A0A, 0, 16'h4000, 16'h5002, 1, 0, 16'h0000, 2'b00, 16'h0A0A, 3};
    tv[5] = '{1, 0, 0, 1, 16'h4001, 16'h0000, 16'h6001, 16'h1357, 1, 16'h4000, 16'h6000, 1, 0, 16'h0000, 2'b00, 16'h1357, 5};
    tv[6] = '{1, 0, 1, 1, 16'h1000, 16'h0000, 16'h7003, 16'h7F00, 0, 16'h1000, 16'h7003, 1, 0, 16'h0000, 2'b00, 16'h007F, 3};
    tv[7] = '{0, 1, 0, 1, 16'h4000, 16'h4444, 16'h5004, 16'h0000, 0, 16'h4000, 16'h5004, 0, 1, 16'h4444, 2'b11, 16'h007F, 3};
    tv[8] = '{1, 1, 0, 0, 16'h0100, 16'h9999, 16'h0000, 16'h2222, 0, 16'h0000, 16'h0100, 1, 0, 16'h0000, 2'b00, 16'h2222, 2};
    tv[9] = '{0, 1, 0, 0, 16'h2003, 16'hABCD, 16'h0000, 16'h0000, 0, 16'h0000, 16'h2002, 0, 1, 16'hABCD, 2'b11, 16'h2222, 2};
    #1;
    chk("rst load", load_data_out, 16'h0000);
    chk("rst addr", dmem_address, 16'h0000);
    chk("rst strobes", {14'd0, dmem_read, dmem_write}, 16'h0000);
    chk("rst stall_done", {14'd0, stall_out, done_out}, 16'h0000);
    chk("rst be_wdata", dmem_wdata | 16'(dmem_byte_enable), 16'h0000);
    @(negedge clk); @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) run_op(i, tv[i]);
    // ALU op right after the STR retires: never stalls, never signals done
    valid_in = 1; mem_read_in = 0; mem_write_in = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("alu stall c%0d", i), 16'(stall_out), 16'h0000);
      chk($sformatf("alu done c%0d", i), 16'(done_out), 16'h0000);
    end
    // stray response while idle must not touch load data
    valid_in = 0; dmem_resp = 1; dmem_rdata = 16'h5A5A;
    @(negedge clk); @(negedge clk);
    chk("idle resp load", load_data_out, 16'h2222);
    chk("idle resp done", 16'(done_out), 16'h0000);
    dmem_resp = 0;
    // STI abandoned by reset while the store is in flight
    @(posedge clk); #1;
    valid_in = 1; mem_read_in = 0; mem_write_in = 1; is_byte_in = 0; is_indirect_in = 1;
    addr_in = 16'h4000; store_data_in = 16'h7777;
    @(negedge clk);
    chk("sti idle stall", 16'(stall_out), 16'h0001);
    @(negedge clk);
    chk("sti ind read", 16'(dmem_read), 16'h0001);
    dmem_resp = 1; dmem_rdata = 16'h6000;
    @(negedge clk);
    dmem_resp = 0;
    chk("sti acc write", 16'(dmem_write), 16'h0001);
    chk("sti acc addr", dmem_address, 16'h6000);
    #1 reset = 1;
    #1;
    chk("sti rst strobes", {14'd0, dmem_read, dmem_write}, 16'h0000);
    chk("sti rst stall", 16'(stall_out), 16'h0000);
    chk("sti rst load", load_data_out, 16'h0000);
    chk("sti rst addr", dmem_address, 16'h0000);
    @(negedge clk);
    valid_in = 0; mem_write_in = 0; is_indirect_in = 0;
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("no retry c%0d", i), {13'd0, dmem_read, dmem_write, stall_out}, 16'h0000);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
